mem_bridge: RTL and testbench

//   Load/store bridge between the multi-cycle core's data port and a handshaked

---
 rtl/mem_bridge_if.sv | 23 ++
 rtl/mem_bridge.sv | 191 +++++++++++++++++++
 tb/tb_mem_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bridge_if.sv
// Memory-side bus of the load/store bridge: one request at a time, held until
// mem_gnt; load data returns later with mem_rvalid.
// master: the bridge; slave: the memory or bus fabric.
interface mem_bridge_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_bridge.sv
// Load/store bridge between the core data port and a word-wide handshaked memory.
// It converts access size and byte offset into a word address, byte enables and
// lane-replicated store data. It also aligns and extends load data, and it returns a
// one-cycle core_ready.
// Optional feature: define BRIDGE_TIMEOUT_EN to abort accesses that stay in
// REQ/WAIT_R for TIMEOUT_CYCLES cycles. An aborted access returns ERR_DATA with
// core_err set.
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  output logic        core_ready,
  output logic [31:0] core_rdata,
  output logic        core_err,
  mem_bridge_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state, state_nxt;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        rsp_upd, rsp_err;
  logic [31:0] rsp_data;
  logic        enter_req;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYCLES must be 1..65535");
  end

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] a,
                                              input logic [1:0] size, input logic uns);
    logic        [31:0] s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    s = word >> {a, 3'b000};
    b = s[7:0];
    h = s[15:0];
    case (size)
      2'b00:   begin ext = b; return uns ? {24'b0, s[7:0]}  : ext; end
      2'b01:   begin ext = h; return uns ? {16'b0, s[15:0]} : ext; end
      default: return s;
    endcase
  endfunction

  assign enter_req = (state == IDLE) && core_req && !misaligned(core_size, core_addr[1:0]);

`ifdef BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Cycles spent in REQ/WAIT_R for the current access; cleared on entry to REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (enter_req) begin
      to_cnt <= '0;
    end else if (state == REQ || state == WAIT_R) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state plus the response to latch when the access completes.
  always_comb begin
    state_nxt = state;
    rsp_upd   = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    case (state)
      IDLE: begin
        if (core_req) begin
          if (misaligned(core_size, core_addr[1:0])) begin
            state_nxt = DONE;
            rsp_upd   = 1'b1;
            rsp_err   = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          if (we_q) begin
            state_nxt = DONE;
            rsp_upd   = 1'b1;
          end else begin
            state_nxt = WAIT_R;
          end
        end else if (timeout_hit) begin
          state_nxt = DONE;
          rsp_upd   = 1'b1;
          rsp_err   = 1'b1;
          rsp_data  = ERR_DATA;
        end
      end
      WAIT_R: begin
        if (mem.mem_rvalid) begin
          state_nxt = DONE;
          rsp_upd   = 1'b1;
          rsp_data  = format_load(mem.mem_rdata, addr_q[1:0], size_q, uns_q);
        end else if (timeout_hit) begin
          state_nxt = DONE;
          rsp_upd   = 1'b1;
          rsp_err   = 1'b1;
          rsp_data  = ERR_DATA;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request latch in IDLE, response registers held until the next DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rdata <= '0;
      core_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && core_req) begin
        we_q    <= core_we;
        uns_q   <= core_unsigned;
        size_q  <= core_size;
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
      end
      if (rsp_upd) begin
        core_rdata <= rsp_data;
        core_err   <= rsp_err;
      end
    end
  end

  assign core_ready   = (state == DONE);
  assign mem.mem_req  = (state == REQ);
  assign mem.mem_we   = we_q && (state == REQ);
  assign mem.mem_addr = {addr_q[31:2], 2'b00};

  // Byte enables and lane-replicated store data from the latched request.
  always_comb begin
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        mem.mem_be    = 4'b0001 << addr_q[1:0];
        mem.mem_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        mem.mem_be    = 4'b0011 << addr_q[1:0];
        mem.mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        mem.mem_be    = 4'b1111;
        mem.mem_wdata = wdata_q;
      end
    endcase
    if (state != REQ) mem.mem_be = 4'b0000;
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed testbench for mem_bridge: reset, byte/half/word stores and loads,
// misalignment, a held request against a slow grant, reset in WAIT_R, stray
// handshakes and the timeout option.
module tb_mem_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [1:0]  core_size = 2'b00;
  logic        core_unsigned = 1'b0;
  logic        core_ready;
  logic [31:0] core_rdata;
  logic        core_err;

  int n_chk = 0;
  int n_fail = 0;

  mem_bridge_if bus();

  mem_bridge #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_size(core_size), .core_unsigned(core_unsigned),
    .core_ready(core_ready), .core_rdata(core_rdata), .core_err(core_err),
    .mem(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns);
    core_req = 1'b1; core_we = we; core_addr = addr;
    core_wdata = wd; core_size = size; core_unsigned = uns;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    if (core_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", core_ready); n_fail++; end n_chk++;
    if (core_err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", core_err); n_fail++; end n_chk++;
    if (core_rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", core_rdata); n_fail++; end n_chk++;
    if (bus.mem_req !== 1'b0) begin $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); n_fail++; end n_chk++;
    if (bus.mem_we !== 1'b0) begin $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); n_fail++; end n_chk++;
    if (bus.mem_be !== 4'h0) begin $display("FAIL reset_mem_be: got %h want 0", bus.mem_be); n_fail++; end n_chk++;
    if (bus.mem_addr !== 32'h0) begin $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); n_fail++; end n_chk++;
    if (bus.mem_wdata !== 32'h0) begin $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); n_fail++; end n_chk++;
    reset = 1'b0;
  endtask

  // Store with grant in the first REQ cycle; core_ready two cycles after accept.
  task automatic test_store(input string nm, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] size, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b1, addr, wd, size, 1'b0);
    tick();
    core_req = 1'b0;
    if (bus.mem_req !== 1'b1) begin $display("FAIL %s_mem_req: got %b want 1", nm, bus.mem_req); n_fail++; end n_chk++;
    if (bus.mem_we !== 1'b1) begin $display("FAIL %s_mem_we: got %b want 1", nm, bus.mem_we); n_fail++; end n_chk++;
    if (bus.mem_addr !== exp_addr) begin $display("FAIL %s_mem_addr: got %h want %h", nm, bus.mem_addr, exp_addr); n_fail++; end n_chk++;
    if (bus.mem_be !== exp_be) begin $display("FAIL %s_mem_be: got %b want %b", nm, bus.mem_be, exp_be); n_fail++; end n_chk++;
    if (bus.mem_wdata !== exp_wd) begin $display("FAIL %s_mem_wdata: got %h want %h", nm, bus.mem_wdata, exp_wd); n_fail++; end n_chk++;
    if (core_ready !== 1'b0) begin $display("FAIL %s_early_ready: got %b want 0", nm, core_ready); n_fail++; end n_chk++;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    if (core_ready !== 1'b1) begin $display("FAIL %s_ready: got %b want 1", nm, core_ready); n_fail++; end n_chk++;
    if (core_err !== 1'b0) begin $display("FAIL %s_err: got %b want 0", nm, core_err); n_fail++; end n_chk++;
    if (core_rdata !== 32'h0) begin $display("FAIL %s_rdata: got %h want 0", nm, core_rdata); n_fail++; end n_chk++;
    tick();
    if (core_ready !== 1'b0) begin $display("FAIL %s_ready_pulse: got %b want 0", nm, core_ready); n_fail++; end n_chk++;
  endtask

  // Load with zero-wait grant and read data one cycle after the grant.
  task automatic test_load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] word, input logic [31:0] exp);
    issue(1'b0, addr, 32'h0, size, uns);
    tick();
    core_req = 1'b0;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
      $display("FAIL %s_req: got req=%b we=%b want req=1 we=0", nm, bus.mem_req, bus.mem_we); n_fail++;
    end n_chk++;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    if (bus.mem_req !== 1'b0 || core_ready !== 1'b0) begin
      $display("FAIL %s_wait: got req=%b ready=%b want 0 0", nm, bus.mem_req, core_ready); n_fail++;
    end n_chk++;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
    tick();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    if (core_ready !== 1'b1) begin $display("FAIL %s_ready: got %b want 1", nm, core_ready); n_fail++; end n_chk++;
    if (core_rdata !== exp) begin $display("FAIL %s_rdata: got %h want %h", nm, core_rdata, exp); n_fail++; end n_chk++;
    if (core_err !== 1'b0) begin $display("FAIL %s_err: got %b want 0", nm, core_err); n_fail++; end n_chk++;
    tick();
  endtask

  task automatic test_misaligned(input string nm, input logic [31:0] addr, input logic [1:0] size);
    issue(1'b0, addr, 32'h0, size, 1'b0);
    tick();
    core_req = 1'b0;
    if (bus.mem_req !== 1'b0) begin $display("FAIL %s_mem_req: got %b want 0", nm, bus.mem_req); n_fail++; end n_chk++;
    if (core_ready !== 1'b1) begin $display("FAIL %s_ready: got %b want 1", nm, core_ready); n_fail++; end n_chk++;
    if (core_err !== 1'b1) begin $display("FAIL %s_err: got %b want 1", nm, core_err); n_fail++; end n_chk++;
    if (core_rdata !== 32'h0) begin $display("FAIL %s_rdata: got %h want 0", nm, core_rdata); n_fail++; end n_chk++;
    tick();
    if (core_ready !== 1'b0 || core_err !== 1'b1 || bus.mem_req !== 1'b0) begin
      $display("FAIL %s_hold: got ready=%b err=%b req=%b want 0 1 0", nm, core_ready, core_err, bus.mem_req); n_fail++;
    end n_chk++;
  endtask

  // Word store whose grant arrives in the 6th REQ cycle while core_req stays high.
  task automatic test_back_to_back();
    int readies = 0;
    issue(1'b1, 32'h200, 32'h11223344, 2'b10, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_be !== 4'hF ||
          bus.mem_wdata !== 32'h11223344 || bus.mem_we !== 1'b1) begin
        $display("FAIL b2b_stable[%0d]: got req=%b addr=%h be=%h wd=%h we=%b want 1 00000200 f 11223344 1",
                 i, bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we);
        n_fail++;
      end
      n_chk++;
      if (core_ready) readies++;
      if (i == 5) bus.mem_gnt = 1'b1;
      tick();
    end
    bus.mem_gnt = 1'b0;
    if (core_ready) readies++;
    tick();
    if (core_ready) readies++;
    if (bus.mem_req !== 1'b0) begin $display("FAIL b2b_idle_req: got %b want 0", bus.mem_req); n_fail++; end n_chk++;
    if (readies !== 1) begin $display("FAIL b2b_ready_count: got %0d want 1", readies); n_fail++; end n_chk++;
    tick();
    core_req = 1'b0;
    if (bus.mem_req !== 1'b1) begin $display("FAIL b2b_second_accept: got %b want 1", bus.mem_req); n_fail++; end n_chk++;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    if (core_ready !== 1'b1) begin $display("FAIL b2b_second_ready: got %b want 1", core_ready); n_fail++; end n_chk++;
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h300, 32'h0, 2'b10, 1'b0);
    tick();
    core_req = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (bus.mem_req !== 1'b0 || core_ready !== 1'b0) begin
      $display("FAIL rstmid_outputs: got req=%b ready=%b want 0 0", bus.mem_req, core_ready); n_fail++;
    end n_chk++;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55667788;
    tick();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    if (core_ready !== 1'b0) begin $display("FAIL rstmid_late_rvalid: got ready=%b want 0", core_ready); n_fail++; end n_chk++;
    tick();
    if (core_ready !== 1'b0 || core_rdata !== 32'h0) begin
      $display("FAIL rstmid_after: got ready=%b rdata=%h want 0 0", core_ready, core_rdata); n_fail++;
    end n_chk++;
  endtask

  task automatic test_stray_handshake();
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    tick(); tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    if (core_ready !== 1'b0 || bus.mem_req !== 1'b0) begin
      $display("FAIL stray_idle: got ready=%b req=%b want 0 0", core_ready, bus.mem_req); n_fail++;
    end n_chk++;
  endtask

  task automatic test_timeout();
    issue(1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
    tick();
    core_req = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    begin
      int waited = -1;
      for (int i = 0; i < 20 && waited < 0; i++) begin
        if (core_ready) waited = i;
        else tick();
      end
      if (waited !== 3) begin $display("FAIL timeout_latency: got %0d want 3", waited); n_fail++; end n_chk++;
      if (core_err !== 1'b1) begin $display("FAIL timeout_err: got %b want 1", core_err); n_fail++; end n_chk++;
      if (core_rdata !== 32'hDEADBEEF) begin $display("FAIL timeout_rdata: got %h want deadbeef", core_rdata); n_fail++; end n_chk++;
      tick();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h01020304;
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      if (core_ready !== 1'b0) begin $display("FAIL timeout_late_rvalid: got ready=%b want 0", core_ready); n_fail++; end n_chk++;
    end
`else
    begin
      int readies = 0;
      for (int i = 0; i < 100; i++) begin
        if (core_ready) readies++;
        tick();
      end
      if (readies !== 0) begin $display("FAIL notimeout_ready: got %0d want 0", readies); n_fail++; end n_chk++;
      if (bus.mem_req !== 1'b0) begin $display("FAIL notimeout_req: got %b want 0", bus.mem_req); n_fail++; end n_chk++;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      if (core_ready !== 1'b1 || core_err !== 1'b0 || core_rdata !== 32'hCAFEF00D) begin
        $display("FAIL notimeout_finish: got ready=%b err=%b rdata=%h want 1 0 cafef00d", core_ready, core_err, core_rdata);
        n_fail++;
      end n_chk++;
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store("sb", 32'h103, 32'h000000AB, 2'b00, 32'h100, 4'b1000, 32'hABABABAB);
    test_load("lb",  32'h102, 2'b00, 1'b0, 32'h12F05678, 32'hFFFFFFF0);
    test_load("lbu", 32'h102, 2'b00, 1'b1, 32'h12F05678, 32'h000000F0);
    test_load("lhu", 32'h102, 2'b01, 1'b1, 32'h12F05678, 32'h000012F0);
    test_load("lh",  32'h102, 2'b01, 1'b0, 32'h12F05678, 32'h000012F0);
    test_load("lhn", 32'h102, 2'b01, 1'b0, 32'h80015678, 32'hFFFF8001);
    test_load("lb3", 32'h103, 2'b00, 1'b0, 32'h12F05678, 32'h00000012);
    test_load("lw",  32'h100, 2'b10, 1'b0, 32'h12F05678, 32'h12F05678);
    test_store("sh", 32'h102, 32'h0000BEEF, 2'b01, 32'h100, 4'b1100, 32'hBEEFBEEF);
    test_misaligned("lh_odd", 32'h101, 2'b01);
    test_misaligned("size11", 32'h100, 2'b11);
    test_back_to_back();
    test_reset_mid();
    test_stray_handshake();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
